// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the reduced RISC-V core: sequences fetch, decode,
// execute, memory and write-back, with memory wait-states and halt on illegal ops.
module multicycle_ctrl #(
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] Instr,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   EQ,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCsrc,
  output logic [1:0]             ImmSrc,
  output logic                   ALUSrc,
  output logic [2:0]             ALUctrl,
  output logic                   RegWrite,
  output logic                   ResultSrc,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ADD, C_ADDI, C_LW, C_SW, C_BNE, C_ILL
  } cls_t;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LD  = 7'd3;
  localparam logic [6:0] OP_ST  = 7'd35;
  localparam logic [6:0] OP_BR  = 7'd99;

  function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
    cls_t c;
    c = C_ILL;
    if      (op == OP_R  && f3 == 3'b000) c = C_ADD;
    else if (op == OP_I  && f3 == 3'b000) c = C_ADDI;
    else if (op == OP_LD && f3 == 3'b010) c = C_LW;
    else if (op == OP_ST && f3 == 3'b010) c = C_SW;
    else if (op == OP_BR && f3 == 3'b001) c = C_BNE;
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [6:0]           op_q;
  logic [2:0]           f3_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 retire;
  cls_t                 cls;
  logic [1:0]           imm_sel;
  logic                 unused_instr;

  assign unused_instr = ^{Instr[INSTR_WIDTH-1:15], Instr[11:7]};

  assign cls     = classify(op_q, f3_q);
  assign imm_sel = (cls == C_SW) ? 2'b01 : (cls == C_BNE) ? 2'b10 : 2'b00;
  assign retired = retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= Instr[6:0];
        f3_q <= Instr[14:12];
      end
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    ImmSrc    = 2'b00;
    ALUSrc    = 1'b0;
    ALUctrl   = 3'b000;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      // Legality is judged on the live IR here; op/f3 are captured at this same edge.
      S_DECODE: begin
        state_d = (classify(Instr[6:0], Instr[14:12]) == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        ImmSrc = imm_sel;
        unique case (cls)
          C_ADD:  state_d = S_WB;
          C_ADDI: begin ALUSrc = 1'b1; state_d = S_WB;  end
          C_LW:   begin ALUSrc = 1'b1; state_d = S_MEM; end
          C_SW:   begin ALUSrc = 1'b1; state_d = S_MEM; end
          C_BNE: begin
            ALUctrl = 3'b001;
            PCWrite = ~EQ;
            PCsrc   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        ImmSrc   = imm_sel;
        MemRead  = (cls == C_LW);
        MemWrite = (cls == C_SW);
        if (dmem_ready) begin
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        ImmSrc    = imm_sel;
        RegWrite  = 1'b1;
        ResultSrc = (cls == C_LW);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      retire    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      ImmSrc    = 2'b00;
      ALUSrc    = 1'b0;
      ALUctrl   = 3'b000;
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule
